// File: rtl/axis_to_uart_tx.sv
// AXI-Stream byte in, asynchronous serial frame out: start, 8 data bits LSB first,
// optional parity, 1 or 2 stop bits. TX and in_tready are registered.
module axis_to_uart_tx #(
  parameter int unsigned CLK_FREQ  = 100_000_000,
  parameter int unsigned BAUD_RATE = 115200,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic [7:0] in_tdata,
  input  logic       in_tvalid,
  output logic       in_tready,
  output logic       TX
);

  localparam int unsigned BitCycles = CLK_FREQ / BAUD_RATE;
  localparam int unsigned TimerW    = $clog2(BitCycles);
  localparam logic [TimerW-1:0] TimerLast = TimerW'(BitCycles - 1);
  localparam logic [2:0] StopLast  = 3'(STOP_BITS - 1);
  localparam bit         HasParity = (PARITY != 0);
  localparam logic       OddParity = (PARITY == 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e            state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              parity_q, parity_d;
  logic              tx_q, tx_d;
  logic              ready_q, ready_d;
  logic              bit_done;

  assign bit_done  = (timer_q == TimerLast);
  assign in_tready = ready_q;
  assign TX        = tx_q;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q   <= StIdle;
      timer_q   <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      tx_q      <= 1'b1;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      tx_q      <= tx_d;
      ready_q   <= ready_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    if (state_q != StIdle) begin
      timer_d = bit_done ? '0 : timer_q + 1'b1;
    end
    case (state_q)
      StIdle: begin
        timer_d   = '0;
        bit_idx_d = '0;
        // Byte and its parity are captured only on the handshake edge.
        if (in_tvalid && ready_q) begin
          shift_d  = in_tdata;
          parity_d = (^in_tdata) ^ OddParity;
          state_d  = StStart;
        end
      end
      StStart: begin
        if (bit_done) begin
          state_d = StData;
        end
      end
      StData: begin
        if (bit_done) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            bit_idx_d = '0;
            state_d   = HasParity ? StParity : StStop;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      StParity: begin
        if (bit_done) begin
          state_d = StStop;
        end
      end
      StStop: begin
        if (bit_done) begin
          if (bit_idx_q == StopLast) begin
            bit_idx_d = '0;
            state_d   = StIdle;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decode the next state so TX and in_tready change on the same edge as the state.
  always_comb begin
    tx_d    = 1'b1;
    ready_d = 1'b0;
    case (state_d)
      StIdle:   ready_d = 1'b1;
      StStart:  tx_d    = 1'b0;
      StData:   tx_d    = shift_d[0];
      StParity: tx_d    = parity_q;
      default:  tx_d    = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_axis_to_uart_tx.sv
// Bench for axis_to_uart_tx: four instances (no parity, even, odd, two stop bits) at 10 cycles
// per bit; accepted bytes go into a scoreboard and are checked cycle by cycle on TX.
module tb_axis_to_uart_tx;

  localparam int unsigned ClkFreq = 10_000_000;
  localparam int unsigned Baud    = 1_000_000;
  localparam int          BitCyc  = 10;

  logic       clk  = 1'b0;
  logic       rstn = 1'b0;
  logic [7:0] data = 8'h00;
  logic [3:0] v    = 4'b0000;
  logic [3:0] rdy;
  logic [3:0] tx;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  axis_to_uart_tx #(.CLK_FREQ(ClkFreq), .BAUD_RATE(Baud), .PARITY(0), .STOP_BITS(1)) dut (
    .aclk(clk), .aresetn(rstn), .in_tdata(data), .in_tvalid(v[0]), .in_tready(rdy[0]), .TX(tx[0])
  );
  axis_to_uart_tx #(.CLK_FREQ(ClkFreq), .BAUD_RATE(Baud), .PARITY(2), .STOP_BITS(1)) dut_even (
    .aclk(clk), .aresetn(rstn), .in_tdata(data), .in_tvalid(v[1]), .in_tready(rdy[1]), .TX(tx[1])
  );
  axis_to_uart_tx #(.CLK_FREQ(ClkFreq), .BAUD_RATE(Baud), .PARITY(1), .STOP_BITS(1)) dut_odd (
    .aclk(clk), .aresetn(rstn), .in_tdata(data), .in_tvalid(v[2]), .in_tready(rdy[2]), .TX(tx[2])
  );
  axis_to_uart_tx #(.CLK_FREQ(ClkFreq), .BAUD_RATE(Baud), .PARITY(0), .STOP_BITS(2)) dut_stop2 (
    .aclk(clk), .aresetn(rstn), .in_tdata(data), .in_tvalid(v[3]), .in_tready(rdy[3]), .TX(tx[3])
  );

  function automatic int par_of(input int idx);
    case (idx)
      1:       return 2;
      2:       return 1;
      default: return 0;
    endcase
  endfunction

  function automatic int stop_of(input int idx);
    return (idx == 3) ? 2 : 1;
  endfunction

  // Drive one handshake on instance idx; the accepted byte is pushed to the scoreboard.
  task automatic accept(input int idx, input logic [7:0] b);
    int t = 0;
    while (rdy[idx] !== 1'b1 && t < 300) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (rdy[idx] !== 1'b1) begin
      fails++;
      $display("FAIL accept_wait: in_tready=%b after %0d cycles, expected 1", rdy[idx], t);
    end
    data   = b;
    v[idx] = 1'b1;
    @(posedge clk);
    exp_q.push_back(b);
    #1 v[idx] = 1'b0;
  endtask

  // Pops the scoreboard and checks every cycle of the frame, then the first idle cycle.
  task automatic check_frame(input int idx, input string name);
    logic [7:0]  b;
    logic [11:0] lb;
    int          nb;
    if (exp_q.size() == 0) begin
      checks++;
      fails++;
      $display("FAIL %s: scoreboard empty, got nothing, expected a queued byte", name);
      return;
    end
    b        = exp_q.pop_front();
    lb       = '1;
    lb[0]    = 1'b0;
    lb[8:1]  = b;
    nb       = 9;
    if (par_of(idx) != 0) begin
      lb[nb] = (par_of(idx) == 1) ? ~(^b) : (^b);
      nb++;
    end
    nb += stop_of(idx);
    for (int k = 0; k < nb; k++) begin
      for (int c = 0; c < BitCyc; c++) begin
        @(negedge clk);
        checks++;
        if (tx[idx] !== lb[k] || rdy[idx] !== 1'b0) begin
          fails++;
          $display("FAIL %s: byte %h line bit %0d cycle %0d got tx=%b rdy=%b, expected tx=%b rdy=0",
                   name, b, k, c, tx[idx], rdy[idx], lb[k]);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (tx[idx] !== 1'b1 || rdy[idx] !== 1'b1) begin
      fails++;
      $display("FAIL %s_idle: byte %h got tx=%b rdy=%b, expected tx=1 rdy=1",
               name, b, tx[idx], rdy[idx]);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (tx[i] !== 1'b1 || rdy[i] !== 1'b0) begin
        fails++;
        $display("FAIL reset_state[%0d]: got tx=%b rdy=%b, expected tx=1 rdy=0", i, tx[i], rdy[i]);
      end
    end
    rstn = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (tx[i] !== 1'b1 || rdy[i] !== 1'b1) begin
        fails++;
        $display("FAIL reset_release[%0d]: got tx=%b rdy=%b, expected tx=1 rdy=1",
                 i, tx[i], rdy[i]);
      end
    end
  endtask

  task automatic test_basic();
    logic [7:0] pats [5] = '{8'hA5, 8'h00, 8'hFF, 8'h3C, 8'h81};
    foreach (pats[i]) begin
      accept(0, pats[i]);
      check_frame(0, "basic");
    end
  endtask

  task automatic test_parity();
    accept(1, 8'hA5);
    check_frame(1, "parity_even_a5");
    accept(2, 8'hA5);
    check_frame(2, "parity_odd_a5");
    accept(1, 8'h01);
    check_frame(1, "parity_even_01");
    accept(2, 8'h01);
    check_frame(2, "parity_odd_01");
  endtask

  task automatic test_back_to_back();
    int t0;
    int t1;
    @(negedge clk);
    data = 8'h00;
    v[3] = 1'b1;
    @(posedge clk);
    #1 t0 = cyc;
    exp_q.push_back(8'h00);
    data = 8'hFF;
    check_frame(3, "b2b_00");
    @(posedge clk);
    #1 t1 = cyc;
    exp_q.push_back(8'hFF);
    v[3] = 1'b0;
    checks++;
    if (t1 - t0 != 111) begin
      fails++;
      $display("FAIL b2b_spacing: accepts %0d cycles apart, expected 111", t1 - t0);
    end
    check_frame(3, "b2b_ff");
  endtask

  task automatic test_data_change();
    @(negedge clk);
    data = 8'h5A;
    v[0] = 1'b1;
    @(posedge clk);
    exp_q.push_back(8'h5A);
    fork
      check_frame(0, "hold_5a");
      begin
        repeat (100) begin
          @(negedge clk);
          data = 8'($urandom);
        end
      end
    join
    v[0] = 1'b0;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (tx[0] !== 1'b1 || rdy[0] !== 1'b1) begin
        fails++;
        $display("FAIL hold_no_second_accept: got tx=%b rdy=%b, expected tx=1 rdy=1",
                 tx[0], rdy[0]);
      end
    end
  endtask

  task automatic test_reset_mid();
    accept(0, 8'h96);
    repeat (45) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    checks++;
    if (tx[0] !== 1'b1 || rdy[0] !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid: got tx=%b rdy=%b, expected tx=1 rdy=0", tx[0], rdy[0]);
    end
    exp_q.delete();
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (tx[0] !== 1'b1 || rdy[0] !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid_release: got tx=%b rdy=%b, expected tx=1 rdy=1", tx[0], rdy[0]);
    end
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      checks++;
      if (tx[0] !== 1'b1) begin
        fails++;
        $display("FAIL reset_mid_quiet: cycle %0d got tx=%b, expected 1", i, tx[0]);
      end
    end
    accept(0, 8'hC3);
    check_frame(0, "after_reset_c3");
  endtask

  task automatic test_all_bytes();
    for (int b = 0; b < 256; b++) begin
      accept(0, 8'(b));
      check_frame(0, "sweep");
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation still running at 1 ms, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_back_to_back();
    test_data_change();
    test_reset_mid();
    test_all_bytes();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/axis_to_uart_tx.md
# axis_to_uart_tx

AXI-Stream to UART serializer: accepts one byte per handshake on a slave AXI-Stream port and transmits it as an asynchronous serial frame (start, 8 data bits LSB first, optional parity, 1 or 2 stop bits) on `TX`. It is the transmit counterpart of `UART_to_AXIS`. It drives the line that a `UART_to_AXIS` receiver samples, and is used for board-to-host output and RX/TX loopback tests.

## Interface
- `CLK_FREQ`, 100_000_000: `aclk` frequency in Hz.
- `BAUD_RATE`, 115200: line rate in bit/s. `BIT_CYCLES = CLK_FREQ / BAUD_RATE`, truncated; must be ≥ 2.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: 1 or 2.

- `aclk`  in  1  the only clock; all logic on the rising edge.
- `aresetn`  in  1  reset, synchronous, active-low.
- `in_tdata`  in  8  byte to transmit.
- `in_tvalid`  in  1  `in_tdata` is valid.
- `in_tready`  out  1  block can accept a byte (registered).
- `TX`  out  1  serial line; idle high (registered, glitch-free).

## Operation
- States:
  - IDLE: `TX`=1 and `in_tready`=1.
  - START: `TX`=0.
  - DATA: `TX`=`shift[0]`, 8 bits.
  - PARITY: only if `PARITY`≠0.
  - STOP: `TX`=1 for `STOP_BITS` bit periods.
- Accept: a rising edge with `in_tvalid && in_tready` latches `in_tdata` into the shift register. On the same edge: state→START, `TX`←0, `in_tready`←0. No other edge changes the latched byte.
- Bit timer: counts 0..`BIT_CYCLES`-1. Each line bit is held for exactly `BIT_CYCLES` cycles. The state or bit index advances on the terminal count.
- DATA: 8 bits, LSB first. A 3-bit index tracks the position. The shift register shifts right at each bit boundary.
- Parity bit: XOR of the 8 data bits. Odd mode inverts it. It is computed from the latched byte.
- STOP: after the last stop period the state returns to IDLE, with `in_tready`←1 on that edge.
- While not ready, `in_tvalid`/`in_tdata` are ignored. The AXI-Stream rule applies to the source: once `in_tvalid` is asserted, it holds it until the handshake.
- No FIFO: single-byte buffering only.

## Timing
- Reset values (while `aresetn`=0 at an edge): state=IDLE, `TX`=1, `in_tready`=0, timer=0, bit index=0.
- `in_tready` rises on the first edge with `aresetn`=1.
- Latency: `TX` falls on the same edge that completes the handshake, so it is visible the cycle after tvalid&tready.
- Frame length `F` = (1 + 8 + (PARITY≠0) + STOP_BITS) × `BIT_CYCLES` cycles. `TX` is high again after the last stop period.
- Back-to-back: the next handshake can occur on the first IDLE cycle. Minimum accept-to-accept spacing is `F`+1 cycles, which leaves exactly one extra idle-high cycle between frames.
- Reset mid-frame: the frame is aborted and the byte lost. `TX`=1 on the next edge. No partial completion after reset is released.
- `BIT_CYCLES` remainder (truncation) is not compensated. The rate error is the user's responsibility.

## Test plan
- Params 10_000_000 / 1_000_000 (`BIT_CYCLES`=10), no parity, 1 stop. Send 0xA5 -> `TX` = 0,1,0,1,0,0,1,0,1,1, each held 10 cycles. `in_tready` is low for 100 cycles and high at cycle 101 after the accept.
- `PARITY`=2, then `PARITY`=1, byte 0xA5 (four ones) -> parity bit is 0 for even and 1 for odd. Frame is 110 cycles.
- `STOP_BITS`=2, continuous `in_tvalid` with 0x00 then 0xFF -> accepts 111 cycles apart. Line is high for exactly 21 cycles between frames.
- `in_tvalid` high with `in_tdata` changing every cycle while a frame is in flight -> transmitted byte equals the value at the handshake edge. No second accept until IDLE.
- Assert `aresetn`=0 during bit 3 of a frame -> `TX`=1 and `in_tready`=0 one edge later. After release, `in_tready`=1 next edge and the next byte transmits cleanly.
- Loopback into `UART_to_AXIS` at 115200 baud, 100 MHz -> all 256 byte values are received in order with no errors.
